rng_draw: RTL and testbench

//   Consumer end of the 2-bit random stream. Packs successive RAND_IN symbols

---
 rtl/rng_pkg.sv | 40 ++++
 rtl/rng_fifo.sv | 76 +++++++
 rtl/rng_draw.sv | 111 +++++++++++
 tb/tb_rng_draw.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared constants and elaboration helpers for the rng_draw slice
//
// Purpose: symbol and counter widths used by rng_draw and rng_fifo, a
//          constant-foldable ceil(log2) and the parameter legality checks
//          that rng_draw applies at elaboration.
// Ports:   none (package)

package rng_pkg;

   localparam int RAND_W = 2;   // bits per raw random symbol
   localparam int REJ_W  = 8;   // width of the saturating reject counter

   // Ceiling log2; clog2(1) == 0. Only ever evaluated on constants.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Candidate width must hold a whole number of symbols.
   function automatic bit width_ok(input int width);
      return (width >= RAND_W) && ((width % RAND_W) == 0);
   endfunction

   // Exclusive bound must leave at least one legal value and fit the candidate space.
   function automatic bit range_ok(input int width, input int range);
      return (range >= 1) && (range <= (1 << width));
   endfunction

   // Pointers wrap naturally, so the depth has to be a power of two.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/rng_fifo.sv
// rtl/rng_fifo.sv - small register-file FIFO holding accepted draws
//
// Purpose: DEPTH-entry FIFO with registered read/write pointers and an
//          occupancy counter. The head entry is presented combinationally
//          from the register file, so a pushed value shows up the cycle
//          after the push edge and never bypasses within the same cycle.
// Ports:
//   CLK    in   1      clock, rising edge
//   RST    in   1      asynchronous active-high reset; empties the FIFO
//   push   in   1      write din on this edge (ignored when full)
//   din    in   W      value to write
//   full   out  1      occupancy == DEPTH
//   pop    in   1      consume the head on this edge (ignored when empty)
//   dout   out  W      head value
//   valid  out  1      FIFO is non-empty

module rng_fifo
   import rng_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign valid   = (count != '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         // Storage is cleared too so the head reads 0 straight out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Push and pop together leave occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rng_draw.sv
// rtl/rng_draw.sv - bounded uniform draws from the 2-bit random symbol stream
//
// Purpose: packs WIDTH/2 successive RAND_IN symbols into a WIDTH-bit
//          candidate, keeps candidates below RANGE (rejection sampling keeps
//          the result uniform over [0, RANGE)) and queues them in rng_fifo
//          for game logic to pull with a valid/ready handshake.
// Ports:
//   CLK         in   1      clock, rising edge
//   RST         in   1      asynchronous active-high reset
//   EN          in   1      sample enable; low holds the partial candidate
//   RAND_IN     in   2      raw random symbol, new every cycle
//   DRAW_VALID  out  1      FIFO head holds an accepted value
//   DRAW_READY  in   1      consumer takes the head this cycle
//   DRAW_VAL    out  WIDTH  FIFO head value, < RANGE whenever DRAW_VALID
//   REJECTS     out  8      saturating count of discarded candidates

module rng_draw
   import rng_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int RANGE = 10,
   parameter int DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [RAND_W-1:0] RAND_IN,
   output logic              DRAW_VALID,
   input  logic              DRAW_READY,
   output logic [WIDTH-1:0]  DRAW_VAL,
   output logic [REJ_W-1:0]  REJECTS
);

   localparam int SYMS  = WIDTH / RAND_W;
   localparam int CNT_W = (SYMS > 1) ? clog2(SYMS) : 1;
   localparam logic [CNT_W-1:0] LAST_SYM    = CNT_W'(SYMS - 1);
   localparam logic [WIDTH:0]   RANGE_BOUND = (WIDTH + 1)'(RANGE);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("rng_draw: WIDTH must be even and >= 2");
      end
      if (!range_ok(WIDTH, RANGE)) begin : g_bad_range
         $error("rng_draw: RANGE must satisfy 1 <= RANGE <= 2**WIDTH");
      end
      if (!depth_ok(DEPTH)) begin : g_bad_depth
         $error("rng_draw: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] sym_cnt;
   logic [REJ_W-1:0] rej_cnt;
   logic [WIDTH-1:0] cand_next;
   logic             fifo_full;
   logic             take;
   logic             last;
   logic             accept;
   logic             push;

   // Fullness is the registered occupancy, so a pop on this edge cannot
   // release a symbol until the following cycle.
   assign take = EN & ~fifo_full;
   assign last = (sym_cnt == LAST_SYM);

   generate
      if (WIDTH == RAND_W) begin : g_single
         assign cand_next = RAND_IN;
      end else begin : g_shift
         assign cand_next = {cand[WIDTH-RAND_W-1:0], RAND_IN};
      end
   endgenerate

   // The oldest symbol is shifted out on completion before it is ever read.
   wire unused_cand_top = ^cand[WIDTH-1:WIDTH-RAND_W];

   // One extra bit so RANGE == 2**WIDTH accepts every candidate.
   assign accept = ({1'b0, cand_next} < RANGE_BOUND);
   assign push   = take & last & accept;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cand    <= '0;
         sym_cnt <= '0;
         rej_cnt <= '0;
      end else if (take) begin
         cand    <= cand_next;
         sym_cnt <= last ? '0 : sym_cnt + CNT_W'(1);
         if (last && !accept && (rej_cnt != '1)) begin
            rej_cnt <= rej_cnt + REJ_W'(1);
         end
      end
   end

   assign REJECTS = rej_cnt;

   rng_fifo #(
      .W     (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   (cand_next),
      .full  (fifo_full),
      .pop   (DRAW_READY),
      .dout  (DRAW_VAL),
      .valid (DRAW_VALID)
   );

endmodule

// File: tb/tb_rng_draw.sv
// tb/tb_rng_draw.sv - scoreboard bench for rng_draw

module tb_rng_draw;

   localparam int WIDTH = 4;
   localparam int RANGE = 10;
   localparam int DEPTH = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             EN = 1'b0;
   logic [1:0]       RAND_IN = 2'b00;
   logic             DRAW_READY = 1'b0;
   logic             DRAW_VALID;
   logic [WIDTH-1:0] DRAW_VAL;
   logic [7:0]       REJECTS;

   rng_draw #(
      .WIDTH (WIDTH),
      .RANGE (RANGE),
      .DEPTH (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (EN),
      .RAND_IN    (RAND_IN),
      .DRAW_VALID (DRAW_VALID),
      .DRAW_READY (DRAW_READY),
      .DRAW_VAL   (DRAW_VAL),
      .REJECTS    (REJECTS)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] exp_q[$];
   int               hist[16];
   logic [WIDTH-1:0] m_cand;
   int               m_cnt;
   int               m_rej;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Packs a symbol the DUT is known to take; queues accepted candidates.
   task automatic model_take(input logic [1:0] sym);
      logic [WIDTH-1:0] nxt;
      nxt    = {m_cand[1:0], sym};
      m_cand = nxt;
      if (m_cnt == 1) begin
         if (int'(nxt) < RANGE) exp_q.push_back(nxt);
         else m_rej++;
         m_cnt = 0;
      end else begin
         m_cnt = 1;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, return just after the rising edge.
   task automatic step(input logic [1:0] sym, input logic en, input logic rdy, input bit taken);
      @(negedge CLK);
      RST        = 1'b0;
      RAND_IN    = sym;
      EN         = en;
      DRAW_READY = rdy;
      if (taken) model_take(sym);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RST        = 1'b1;
      EN         = 1'b0;
      DRAW_READY = 1'b0;
      RAND_IN    = 2'b00;
      exp_q.delete();
      m_cand = '0;
      m_cnt  = 0;
      m_rej  = 0;
      repeat (2) @(negedge CLK);
      #1;
      chk("reset_valid", 32'(DRAW_VALID), 0);
      chk("reset_val", 32'(DRAW_VAL), 0);
      chk("reset_rejects", 32'(REJECTS), 0);
   endtask

   // Monitor: pops the scoreboard whenever a handshake will complete on the next edge.
   initial begin : monitor
      logic             prev_stall;
      logic [WIDTH-1:0] held;
      logic [WIDTH-1:0] e;
      prev_stall = 1'b0;
      held       = '0;
      forever begin
         @(negedge CLK);
         #1;
         if (RST) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("stall_hold", 32'({DRAW_VALID, DRAW_VAL}), 32'({1'b1, held}));
            if (DRAW_VALID) begin
               total++;
               if (!(int'(DRAW_VAL) < RANGE)) begin
                  bad++;
                  $display("FAIL val_in_range actual=%0d limit=%0d @%0t", DRAW_VAL, RANGE, $time);
               end
               if (DRAW_READY) begin
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_draw actual=%0d required=none @%0t", DRAW_VAL, $time);
                  end else begin
                     e = exp_q.pop_front();
                     chk("pop_value", 32'(DRAW_VAL), 32'(e));
                     hist[DRAW_VAL]++;
                  end
                  prev_stall = 1'b0;
               end else begin
                  prev_stall = 1'b1;
                  held       = DRAW_VAL;
               end
            end else begin
               prev_stall = 1'b0;
            end
         end
      end
   end

   initial begin : stimulus
      logic [1:0] s;
      logic       en;
      int         lo;
      int         hi;

      for (int i = 0; i < 16; i++) hist[i] = 0;

      // 1: first draw, 01 then 10 -> 6 visible after the second edge
      do_reset();
      step(2'b01, 1'b1, 1'b1, 1'b1);
      chk("t1_not_yet_valid", 32'(DRAW_VALID), 0);
      step(2'b10, 1'b1, 1'b1, 1'b1);
      chk("t1_valid", 32'(DRAW_VALID), 1);
      chk("t1_val", 32'(DRAW_VAL), 6);
      chk("t1_rejects", 32'(REJECTS), 0);

      // 2: 0xF rejected, then 3 accepted
      step(2'b11, 1'b1, 1'b1, 1'b1);
      step(2'b11, 1'b1, 1'b1, 1'b1);
      chk("t2_rejects", 32'(REJECTS), 1);
      chk("t2_empty_after_reject", 32'(DRAW_VALID), 0);
      step(2'b00, 1'b1, 1'b1, 1'b1);
      step(2'b11, 1'b1, 1'b1, 1'b1);
      chk("t2_val", 32'(DRAW_VAL), 3);
      step(2'b00, 1'b0, 1'b1, 1'b0);

      // 3: fill with 1,2,3,4 under stall; extra symbols must be ignored while full
      step(2'b00, 1'b1, 1'b0, 1'b1);
      step(2'b01, 1'b1, 1'b0, 1'b1);
      step(2'b00, 1'b1, 1'b0, 1'b1);
      step(2'b10, 1'b1, 1'b0, 1'b1);
      step(2'b00, 1'b1, 1'b0, 1'b1);
      step(2'b11, 1'b1, 1'b0, 1'b1);
      step(2'b01, 1'b1, 1'b0, 1'b1);
      step(2'b00, 1'b1, 1'b0, 1'b1);
      chk("t3_full_valid", 32'(DRAW_VALID), 1);
      chk("t3_full_head", 32'(DRAW_VAL), 1);
      repeat (3) step(2'b11, 1'b1, 1'b0, 1'b0);
      // pop edge: still full at cycle start, so this symbol is not taken
      step(2'b11, 1'b1, 1'b1, 1'b0);
      chk("t3_head_after_pop", 32'(DRAW_VAL), 2);
      step(2'b01, 1'b1, 1'b0, 1'b1);
      step(2'b01, 1'b1, 1'b0, 1'b1);
      chk("t3_rejects_unchanged", 32'(REJECTS), 1);
      repeat (6) step(2'b00, 1'b0, 1'b1, 1'b0);
      chk("t3_drained", 32'(DRAW_VALID), 0);
      chk("t3_queue_empty", 32'(exp_q.size()), 0);

      // 4: all-ones stream saturates the reject counter
      for (int i = 0; i < 600; i++) begin
         step(2'b11, 1'b1, 1'b1, 1'b1);
         if (i == 505) chk("t4_rejects_254", 32'(REJECTS), 254);
         if (i == 507) chk("t4_rejects_255", 32'(REJECTS), 255);
      end
      chk("t4_rejects_sat", 32'(REJECTS), 255);
      chk("t4_no_valid", 32'(DRAW_VALID), 0);

      // 5: reset mid-candidate with two entries queued
      step(2'b01, 1'b1, 1'b0, 1'b1);
      step(2'b11, 1'b1, 1'b0, 1'b1);
      step(2'b10, 1'b1, 1'b0, 1'b1);
      step(2'b00, 1'b1, 1'b0, 1'b1);
      step(2'b10, 1'b1, 1'b0, 1'b1);
      chk("t5_two_queued_head", 32'(DRAW_VAL), 7);
      @(negedge CLK);
      #3;
      RST = 1'b1;
      #1;
      chk("t5_async_valid", 32'(DRAW_VALID), 0);
      chk("t5_async_val", 32'(DRAW_VAL), 0);
      chk("t5_async_rejects", 32'(REJECTS), 0);
      do_reset();
      step(2'b00, 1'b1, 1'b1, 1'b1);
      chk("t5_fresh_count", 32'(DRAW_VALID), 0);
      step(2'b01, 1'b1, 1'b1, 1'b1);
      chk("t5_first_valid", 32'(DRAW_VALID), 1);
      chk("t5_first_val", 32'(DRAW_VAL), 1);

      // 6: random symbols and enable, consumer always ready
      for (int i = 0; i < 16; i++) hist[i] = 0;
      for (int i = 0; i < 6000; i++) begin
         s  = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 3) != 0);
         step(s, en, 1'b1, en);
      end
      repeat (4) step(2'b00, 1'b0, 1'b1, 1'b0);
      chk("t6_queue_empty", 32'(exp_q.size()), 0);
      chk("t6_drained", 32'(DRAW_VALID), 0);
      chk("t6_rejects", 32'(REJECTS), 32'((m_rej > 255) ? 255 : m_rej));
      lo = 90;
      hi = 190;
      for (int v = 0; v < RANGE; v++) begin
         total++;
         if (hist[v] < lo || hist[v] > hi) begin
            bad++;
            $display("FAIL hist_bin_%0d actual=%0d required=%0d..%0d", v, hist[v], lo, hi);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
